// File: rtl/rob_multi_commit_pkg.sv
// rtl/rob_multi_commit_pkg.sv - ROB operation codes and entry layout
// Shared by the reorder buffer, its commit selector and the bench.
package rob_multi_commit_pkg;

  localparam int ROB_XLEN = 32;

  typedef enum logic [1:0] {
    ROB_REG   = 2'd0,
    ROB_STORE = 2'd1,
    ROB_BR    = 2'd2
  } rob_op_t;

  typedef struct packed {
    logic                busy;
    logic                ready;
    rob_op_t             op;
    logic [4:0]          rd;
    logic [ROB_XLEN-1:0] data;
    logic [ROB_XLEN-1:0] pred_pc;
    logic [ROB_XLEN-1:0] act_pc;
  } rob_entry_t;

endpackage

// File: rtl/rob_commit_sel.sv
// rtl/rob_commit_sel.sv - in-order retire selection over the head window
// Lane k retires only if every older lane retired and none was a store or a mispredict.
module rob_commit_sel
  import rob_multi_commit_pkg::*;
#(
  parameter  int COMMIT_W = 2,
  localparam int LANE_W   = (COMMIT_W > 1) ? $clog2(COMMIT_W) : 1,
  localparam int CNT_W    = $clog2(COMMIT_W + 1)
) (
  input  logic [COMMIT_W-1:0] lane_busy,
  input  logic [COMMIT_W-1:0] lane_ready,
  input  logic [COMMIT_W-1:0] lane_pc_miss,
  input  rob_op_t             lane_op [COMMIT_W],
  input  logic                store_ack,
  output logic [COMMIT_W-1:0] retire,
  output logic                mis_valid,
  output logic [LANE_W-1:0]   mis_lane,
  output logic [CNT_W-1:0]    retire_cnt
);

  logic chain;

  always_comb begin
    retire     = '0;
    mis_valid  = 1'b0;
    mis_lane   = '0;
    retire_cnt = '0;
    chain      = 1'b1;
    for (int k = 0; k < COMMIT_W; k++) begin
      if (chain && lane_busy[k] && lane_ready[k] &&
          (lane_op[k] != ROB_STORE || (k == 0 && store_ack))) begin
        retire[k]  = 1'b1;
        retire_cnt = retire_cnt + CNT_W'(1);
        if (lane_op[k] == ROB_STORE) chain = 1'b0;
        if (lane_op[k] == ROB_BR && lane_pc_miss[k]) begin
          mis_valid = 1'b1;
          mis_lane  = LANE_W'(k);
          chain     = 1'b0;
        end
      end else begin
        chain = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rob_multi_commit.sv
// rtl/rob_multi_commit.sv - multi-commit reorder buffer with CDB write-back and flush
// XLEN must equal ROB_XLEN since entries use the shared packed layout.
module rob_multi_commit
  import rob_multi_commit_pkg::*;
#(
  parameter  int DEPTH    = 8,
  parameter  int NUM_CDB  = 3,
  parameter  int COMMIT_W = 2,
  parameter  int XLEN     = ROB_XLEN,
  localparam int TAG_W    = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      disp_valid,
  output logic                      disp_ready,
  input  rob_op_t                   disp_op,
  input  logic [4:0]                disp_rd,
  input  logic [XLEN-1:0]           disp_pred_pc,
  output logic [TAG_W-1:0]          disp_tag,
  input  logic [NUM_CDB-1:0]        cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
  input  logic [NUM_CDB*XLEN-1:0]   cdb_data,
  input  logic [NUM_CDB*XLEN-1:0]   cdb_target,
  input  logic [2*TAG_W-1:0]        q_tag,
  output logic [1:0]                q_ready,
  output logic [2*XLEN-1:0]         q_data,
  output logic [COMMIT_W-1:0]       commit_valid,
  output logic [COMMIT_W*5-1:0]     commit_rd,
  output logic [COMMIT_W*XLEN-1:0]  commit_data,
  output logic [COMMIT_W*TAG_W-1:0] commit_tag,
  output logic                      store_commit,
  input  logic                      store_ack,
  output logic                      flush,
  output logic [XLEN-1:0]           flush_pc,
  output logic [TAG_W:0]            count
);

  localparam int CNT_W  = TAG_W + 1;
  localparam int LANE_W = (COMMIT_W > 1) ? $clog2(COMMIT_W) : 1;
  localparam int RCNT_W = $clog2(COMMIT_W + 1);

  rob_entry_t          entries_q [DEPTH];
  rob_entry_t          entries_d [DEPTH];
  logic [TAG_W-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                flush_q, flush_d;
  logic [XLEN-1:0]     flush_pc_q, flush_pc_d;

  rob_entry_t          win [COMMIT_W];
  rob_op_t             lane_op [COMMIT_W];
  logic [COMMIT_W-1:0] lane_busy, lane_ready, lane_pc_miss, retire;
  logic                mis_valid;
  logic [LANE_W-1:0]   mis_lane;
  logic [RCNT_W-1:0]   retire_cnt;
  logic                disp_fire;
  logic [TAG_W-1:0]    q_idx [2];

  // Registered count only: a slot freed by this cycle's commit is not reusable until next cycle.
  assign disp_ready   = (count_q < CNT_W'(DEPTH)) && !flush_q;
  assign disp_fire    = disp_valid && disp_ready;
  assign disp_tag     = tail_q;
  assign count        = count_q;
  assign flush        = flush_q;
  assign flush_pc     = flush_pc_q;
  assign store_commit = win[0].busy && win[0].ready && (win[0].op == ROB_STORE);

  always_comb begin
    win          = '{default: '0};
    lane_op      = '{default: ROB_REG};
    lane_busy    = '0;
    lane_ready   = '0;
    lane_pc_miss = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      win[k]          = entries_q[head_q + TAG_W'(k)];
      lane_op[k]      = win[k].op;
      lane_busy[k]    = win[k].busy;
      lane_ready[k]   = win[k].ready;
      lane_pc_miss[k] = (win[k].act_pc != win[k].pred_pc);
    end
  end

  rob_commit_sel #(.COMMIT_W(COMMIT_W)) u_sel (
    .lane_busy    (lane_busy),
    .lane_ready   (lane_ready),
    .lane_pc_miss (lane_pc_miss),
    .lane_op      (lane_op),
    .store_ack    (store_ack),
    .retire       (retire),
    .mis_valid    (mis_valid),
    .mis_lane     (mis_lane),
    .retire_cnt   (retire_cnt)
  );

  always_comb begin
    commit_valid = '0;
    commit_rd    = '0;
    commit_data  = '0;
    commit_tag   = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      commit_valid[k] = retire[k] && (win[k].op != ROB_STORE) && (win[k].rd != 5'd0);
      if (commit_valid[k]) begin
        commit_rd[k*5 +: 5]           = win[k].rd;
        commit_data[k*XLEN +: XLEN]   = win[k].data;
        commit_tag[k*TAG_W +: TAG_W]  = head_q + TAG_W'(k);
      end
    end
  end

  // Lowest CDB channel is scanned last so it overrides higher ones on a tag clash.
  always_comb begin
    q_ready = '0;
    q_data  = '0;
    q_idx   = '{default: '0};
    for (int i = 0; i < 2; i++) begin
      q_idx[i] = q_tag[i*TAG_W +: TAG_W];
      if (entries_q[q_idx[i]].busy) begin
        if (entries_q[q_idx[i]].ready) begin
          q_ready[i]               = 1'b1;
          q_data[i*XLEN +: XLEN]   = entries_q[q_idx[i]].data;
        end else begin
          for (int c = NUM_CDB - 1; c >= 0; c--) begin
            if (cdb_valid[c] && (cdb_tag[c*TAG_W +: TAG_W] == q_idx[i])) begin
              q_ready[i]             = 1'b1;
              q_data[i*XLEN +: XLEN] = cdb_data[c*XLEN +: XLEN];
            end
          end
        end
      end
    end
  end

  always_comb begin
    entries_d  = entries_q;
    head_d     = head_q + TAG_W'(retire_cnt);
    tail_d     = tail_q + TAG_W'(disp_fire);
    count_d    = count_q + CNT_W'(disp_fire) - CNT_W'(retire_cnt);
    flush_d    = 1'b0;
    flush_pc_d = flush_pc_q;
    for (int c = NUM_CDB - 1; c >= 0; c--) begin
      if (cdb_valid[c] && entries_q[cdb_tag[c*TAG_W +: TAG_W]].busy) begin
        entries_d[cdb_tag[c*TAG_W +: TAG_W]].ready  = 1'b1;
        entries_d[cdb_tag[c*TAG_W +: TAG_W]].data   = cdb_data[c*XLEN +: XLEN];
        entries_d[cdb_tag[c*TAG_W +: TAG_W]].act_pc = cdb_target[c*XLEN +: XLEN];
      end
    end
    for (int k = 0; k < COMMIT_W; k++) begin
      if (retire[k]) entries_d[head_q + TAG_W'(k)] = '0;
    end
    if (disp_fire) begin
      entries_d[tail_q]         = '0;
      entries_d[tail_q].busy    = 1'b1;
      entries_d[tail_q].op      = disp_op;
      entries_d[tail_q].rd      = disp_rd;
      entries_d[tail_q].pred_pc = disp_pred_pc;
    end
    if (mis_valid) begin
      flush_d    = 1'b1;
      flush_pc_d = win[mis_lane].act_pc;
      entries_d  = '{default: '0};
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      flush_q    <= 1'b0;
      flush_pc_q <= '0;
    end else begin
      entries_q  <= entries_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      flush_q    <= flush_d;
      flush_pc_q <= flush_pc_d;
    end
  end

endmodule

// File: tb/tb_rob_multi_commit.sv
// tb/tb_rob_multi_commit.sv - directed self-checking bench for rob_multi_commit
// Linear directed steps; inputs change 1ns after posedge, checks follow.
module tb_rob_multi_commit;
  import rob_multi_commit_pkg::*;

  localparam int DEPTH    = 8;
  localparam int NUM_CDB  = 3;
  localparam int COMMIT_W = 2;
  localparam int XLEN     = 32;
  localparam int TAG_W    = $clog2(DEPTH);

  logic                      clk, rst;
  logic                      disp_valid, disp_ready;
  rob_op_t                   disp_op;
  logic [4:0]                disp_rd;
  logic [XLEN-1:0]           disp_pred_pc;
  logic [TAG_W-1:0]          disp_tag;
  logic [NUM_CDB-1:0]        cdb_valid;
  logic [NUM_CDB*TAG_W-1:0]  cdb_tag;
  logic [NUM_CDB*XLEN-1:0]   cdb_data, cdb_target;
  logic [2*TAG_W-1:0]        q_tag;
  logic [1:0]                q_ready;
  logic [2*XLEN-1:0]         q_data;
  logic [COMMIT_W-1:0]       commit_valid;
  logic [COMMIT_W*5-1:0]     commit_rd;
  logic [COMMIT_W*XLEN-1:0]  commit_data;
  logic [COMMIT_W*TAG_W-1:0] commit_tag;
  logic                      store_commit, store_ack, flush;
  logic [XLEN-1:0]           flush_pc;
  logic [TAG_W:0]            count;

  int total = 0;
  int bad   = 0;

  rob_multi_commit #(.DEPTH(DEPTH), .NUM_CDB(NUM_CDB), .COMMIT_W(COMMIT_W), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op), .disp_rd(disp_rd),
    .disp_pred_pc(disp_pred_pc), .disp_tag(disp_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_target(cdb_target),
    .q_tag(q_tag), .q_ready(q_ready), .q_data(q_data),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_data(commit_data),
    .commit_tag(commit_tag), .store_commit(store_commit), .store_ack(store_ack),
    .flush(flush), .flush_pc(flush_pc), .count(count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    disp_valid   = 1'b0;
    disp_op      = ROB_REG;
    disp_rd      = '0;
    disp_pred_pc = '0;
    cdb_valid    = '0;
    cdb_tag      = '0;
    cdb_data     = '0;
    cdb_target   = '0;
    q_tag        = '0;
    store_ack    = 1'b0;
  endtask

  task automatic set_cdb(input int ch, input logic [TAG_W-1:0] t, input logic [XLEN-1:0] d,
                         input logic [XLEN-1:0] tg);
    cdb_valid[ch]                = 1'b1;
    cdb_tag[ch*TAG_W +: TAG_W]   = t;
    cdb_data[ch*XLEN +: XLEN]    = d;
    cdb_target[ch*XLEN +: XLEN]  = tg;
  endtask

  task automatic disp(input rob_op_t op, input logic [4:0] rd, input logic [XLEN-1:0] pc);
    disp_valid   = 1'b1;
    disp_op      = op;
    disp_rd      = rd;
    disp_pred_pc = pc;
    tick();
    disp_valid   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clr();
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    clr();
    tick();
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_commit_valid", 64'(commit_valid), 64'(0));
    chk("rst_store_commit", 64'(store_commit), 64'(0));
    chk("rst_flush", 64'(flush), 64'(0));
    chk("rst_q_ready", 64'(q_ready), 64'(0));
    rst = 1'b1;
    #1;
    chk("rel_disp_ready", 64'(disp_ready), 64'(1));
    chk("rel_disp_tag", 64'(disp_tag), 64'(0));

    // Three REGs completed out of order on three channels, retired two then one.
    disp(ROB_REG, 5'd1, '0);
    disp(ROB_REG, 5'd2, '0);
    chk("t1_disp_tag", 64'(disp_tag), 64'(2));
    disp(ROB_REG, 5'd3, '0);
    chk("t1_count3", 64'(count), 64'(3));
    chk("t1_no_commit", 64'(commit_valid), 64'(0));
    set_cdb(0, 3'd2, 32'h300, '0);
    set_cdb(1, 3'd1, 32'h200, '0);
    set_cdb(2, 3'd0, 32'h100, '0);
    tick();
    cdb_valid = '0;
    chk("t1_cv_both", 64'(commit_valid), 64'(2'b11));
    chk("t1_rd_both", 64'(commit_rd), 64'({5'd2, 5'd1}));
    chk("t1_data_both", 64'(commit_data), {32'h200, 32'h100});
    chk("t1_tag_both", 64'(commit_tag), 64'({3'd1, 3'd0}));
    tick();
    chk("t1_cv_one", 64'(commit_valid), 64'(2'b01));
    chk("t1_rd_one", 64'(commit_rd), 64'(3));
    chk("t1_data_one", 64'(commit_data), 64'(32'h300));
    chk("t1_tag_one", 64'(commit_tag), 64'(2));
    chk("t1_count1", 64'(count), 64'(1));
    tick();
    chk("t1_count0", 64'(count), 64'(0));
    chk("t1_cv_idle", 64'(commit_valid), 64'(0));

    // Fill to DEPTH; commit in the full cycle must not let a dispatch in.
    do_reset();
    for (int i = 0; i < DEPTH; i++) disp(ROB_REG, 5'(i + 1), '0);
    chk("t2_full_count", 64'(count), 64'(8));
    chk("t2_full_ready", 64'(disp_ready), 64'(0));
    set_cdb(0, 3'd0, 32'hA0, '0);
    disp_valid = 1'b1;
    disp_op    = ROB_REG;
    disp_rd    = 5'd9;
    tick();
    cdb_valid = '0;
    chk("t2_commit_head", 64'(commit_valid), 64'(2'b01));
    chk("t2_commit_rd", 64'(commit_rd), 64'(1));
    chk("t2_blocked_ready", 64'(disp_ready), 64'(0));
    chk("t2_blocked_count", 64'(count), 64'(8));
    tick();
    chk("t2_after_count", 64'(count), 64'(7));
    chk("t2_after_ready", 64'(disp_ready), 64'(1));
    chk("t2_wrap_tag", 64'(disp_tag), 64'(0));
    tick();
    disp_valid = 1'b0;
    chk("t2_refill_count", 64'(count), 64'(8));
    chk("t2_tail_next", 64'(disp_tag), 64'(1));

    // Store at head waits for ack, then retires alone.
    do_reset();
    disp(ROB_STORE, 5'd0, '0);
    disp(ROB_REG, 5'd5, '0);
    set_cdb(0, 3'd0, 32'h55, '0);
    set_cdb(1, 3'd1, 32'h77, '0);
    tick();
    cdb_valid = '0;
    for (int r = 0; r < 3; r++) begin
      chk("t3_wait_store_commit", 64'(store_commit), 64'(1));
      chk("t3_wait_cv", 64'(commit_valid), 64'(0));
      chk("t3_wait_count", 64'(count), 64'(2));
      tick();
    end
    store_ack = 1'b1;
    #1;
    chk("t3_ack_store_commit", 64'(store_commit), 64'(1));
    chk("t3_ack_alone", 64'(commit_valid), 64'(0));
    tick();
    store_ack = 1'b0;
    chk("t3_post_store_commit", 64'(store_commit), 64'(0));
    chk("t3_post_count", 64'(count), 64'(1));
    chk("t3_reg_cv", 64'(commit_valid), 64'(2'b01));
    chk("t3_reg_rd", 64'(commit_rd), 64'(5));
    chk("t3_reg_data", 64'(commit_data), 64'(32'h77));
    chk("t3_reg_tag", 64'(commit_tag), 64'(1));
    tick();
    chk("t3_count0", 64'(count), 64'(0));

    // Mispredicted branch at head (tag 2) with a ready REG behind it.
    disp(ROB_BR, 5'd1, 32'h60);
    disp(ROB_REG, 5'd6, '0);
    set_cdb(0, 3'd2, 32'h1004, 32'h40);
    set_cdb(1, 3'd3, 32'h66, '0);
    tick();
    cdb_valid = '0;
    chk("t4_br_cv", 64'(commit_valid), 64'(2'b01));
    chk("t4_br_rd", 64'(commit_rd), 64'(1));
    chk("t4_br_data", 64'(commit_data), 64'(32'h1004));
    chk("t4_br_tag", 64'(commit_tag), 64'(2));
    chk("t4_no_flush_yet", 64'(flush), 64'(0));
    tick();
    chk("t4_flush", 64'(flush), 64'(1));
    chk("t4_flush_pc", 64'(flush_pc), 64'(32'h40));
    chk("t4_flush_count", 64'(count), 64'(0));
    chk("t4_flush_ready", 64'(disp_ready), 64'(0));
    chk("t4_flush_cv", 64'(commit_valid), 64'(0));
    tick();
    chk("t4_flush_end", 64'(flush), 64'(0));
    chk("t4_ready_again", 64'(disp_ready), 64'(1));

    // Operand query forwarding from CDB, lowest channel first.
    for (int i = 0; i < 5; i++) disp(ROB_REG, 5'(10 + i), '0);
    q_tag = {3'd3, 3'd4};
    set_cdb(1, 3'd4, 32'hDEADBEEF, '0);
    set_cdb(2, 3'd4, 32'h12345678, '0);
    #1;
    chk("t5_fwd_ready", 64'(q_ready), 64'(2'b01));
    chk("t5_fwd_data", 64'(q_data[XLEN-1:0]), 64'(32'hDEADBEEF));
    tick();
    cdb_valid = '0;
    #1;
    chk("t5_stored_ready", 64'(q_ready), 64'(2'b01));
    chk("t5_stored_data", 64'(q_data[XLEN-1:0]), 64'(32'hDEADBEEF));
    chk("t5_count", 64'(count), 64'(5));
    chk("t5_no_commit", 64'(commit_valid), 64'(0));

    // Asynchronous reset while 5 entries are busy and the head is committing.
    set_cdb(0, 3'd0, 32'h11, '0);
    tick();
    cdb_valid = '0;
    #1;
    chk("t6_pre_cv", 64'(commit_valid), 64'(2'b01));
    #2;
    rst = 1'b0;
    #1;
    chk("t6_async_count", 64'(count), 64'(0));
    chk("t6_async_cv", 64'(commit_valid), 64'(0));
    chk("t6_async_q_ready", 64'(q_ready), 64'(0));
    chk("t6_async_store", 64'(store_commit), 64'(0));
    chk("t6_async_flush", 64'(flush), 64'(0));
    chk("t6_async_rd", 64'(commit_rd), 64'(0));
    tick();
    rst = 1'b1;
    q_tag = '0;
    #1;
    chk("t6_rel_ready", 64'(disp_ready), 64'(1));
    chk("t6_rel_count", 64'(count), 64'(0));
    chk("t6_rel_tag", 64'(disp_tag), 64'(0));

    // Reset mid-store: store_commit drops at once and a late ack does nothing.
    disp(ROB_STORE, 5'd0, '0);
    set_cdb(0, 3'd0, 32'h99, '0);
    tick();
    cdb_valid = '0;
    chk("t7_store_up", 64'(store_commit), 64'(1));
    #2;
    rst = 1'b0;
    #1;
    chk("t7_store_drop", 64'(store_commit), 64'(0));
    tick();
    rst = 1'b1;
    store_ack = 1'b1;
    tick();
    store_ack = 1'b0;
    chk("t7_late_ack_count", 64'(count), 64'(0));
    chk("t7_late_ack_store", 64'(store_commit), 64'(0));
    chk("t7_late_ack_cv", 64'(commit_valid), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rob_multi_commit.md
Name: rob_multi_commit

Overview:
Parametrised reorder buffer for the Tomasulo core, replacing the fixed single-commit ROB. It supports configurable depth, any number of CDB write-back channels, and up to COMMIT_W in-order retirements per cycle. It also provides two operand look-up ports for the decoder, a store-retire handshake toward the LSB, and branch-mispredict flush generation with a correct-PC output. It sits between the decoder (dispatch), the reservation stations/CDB (write-back), the regfile (commit) and the branch predictor (flush).

Parameters:
DEPTH, 8, number of entries; power of two, at least 2; TAG_W = $clog2(DEPTH) (localparam).
NUM_CDB, 3, number of CDB write-back channels (alu, cmp, mem).
COMMIT_W, 2, maximum retirements per cycle; range 1 to DEPTH.
XLEN, 32, data and PC width.

Ports:
clk  in  1  sole clock.
rst  in  1  reset; one clock; reset is asynchronous and active-low.
disp_valid  in  1  decoder presents an instruction.
disp_ready  out  1  high when count < DEPTH and flush == 0.
disp_op  in  2  rob_op_t: ROB_REG, ROB_STORE, ROB_BR.
disp_rd  in  5  destination register; 0 means no write.
disp_pred_pc  in  XLEN  predicted next PC (branches only).
disp_tag  out  TAG_W  tag allocated to the dispatching instruction; equals tail.
cdb_valid  in  NUM_CDB  per-channel write-back strobe.
cdb_tag  in  NUM_CDB*TAG_W  per-channel ROB tag.
cdb_data  in  NUM_CDB*XLEN  per-channel result.
cdb_target  in  NUM_CDB*XLEN  actual next PC; meaningful for ROB_BR entries.
q_tag  in  2*TAG_W  operand query tags.
q_ready  out  2  queried entry is busy and its value is available.
q_data  out  2*XLEN  queried value.
commit_valid  out  COMMIT_W  per-lane regfile write.
commit_rd  out  COMMIT_W*5  per-lane destination.
commit_data  out  COMMIT_W*XLEN  per-lane value.
commit_tag  out  COMMIT_W*TAG_W  per-lane tag; the regfile clears Qi only if it still matches.
store_commit  out  1  head is a ready store; LSB may write memory.
store_ack  in  1  LSB finished the store.
flush  out  1  one-cycle pulse after a mispredicted branch retires.
flush_pc  out  XLEN  correct PC; valid while flush is high.
count  out  TAG_W+1  occupied entries.

Behaviour:
- Entry fields: busy, ready, op, rd, data, pred_pc, act_pc. State: head, tail, count registers.
- Reset (rst = 0, asynchronous):
  - All entries are cleared and head = tail = count = 0.
  - flush = 0. commit_valid = 0. store_commit = 0. q_ready = 0.
  - disp_ready = 1 once rst is released.
- Dispatch: on disp_valid && disp_ready, write entry[tail] with busy = 1 and ready = 0, then tail increments (wrapping at DEPTH). disp_ready is derived from the registered count only; there is no same-cycle bypass from commit.
- Write-back:
  - For each channel c with cdb_valid[c] and entry[cdb_tag[c]].busy, set ready = 1 and latch data and act_pc.
  - If two channels carry the same tag in one cycle, the lowest c wins.
  - A CDB write to a non-busy entry is ignored.
- Operand query:
  - q_ready[i] = entry busy && ready.
  - Otherwise, a same-cycle CDB hit on q_tag[i] forwards the CDB data with q_ready[i] = 1, lowest channel first.
- Commit lane k (0..COMMIT_W-1) examines entry head+k. It retires only if all of the following hold:
  - all lanes below k retired;
  - the entry is busy and ready;
  - the entry is not a store when k > 0;
  - no lane below k is a mispredicted branch.
- ROB_REG and ROB_BR commits drive commit_valid = (rd != 0), with rd, data and tag.
- Stores:
  - store_commit is combinational: head busy && ready && op == ROB_STORE.
  - The store entry retires in the cycle store_ack is high.
  - A store retires alone; commit_valid stays 0 for it.
- Mispredict:
  - A ROB_BR entry with act_pc != pred_pc retires normally in its lane (link register written).
  - Lanes above it are suppressed.
  - Next cycle: flush = 1 and flush_pc = act_pc. All entries clear, head = tail = count = 0, and disp_ready = 0 during flush.
- Counters: count_next = count + dispatched - retired. head advances by the number retired, modulo DEPTH. count distinguishes full from empty when head == tail.
- Full with simultaneous commit: dispatch stays blocked that cycle.
- Reset mid-store: store_commit drops immediately; a late store_ack is ignored.

Decomposition:
- rv32i_types gains:
  - rob_op_t enum (ROB_REG, ROB_STORE, ROB_BR);
  - rob_entry_t packed struct (busy, ready, op, rd, data, pred_pc, act_pc).
- One sub-module, rob_commit_sel: purely combinational. It takes the COMMIT_W head-window entries and store_ack, and produces per-lane retire enables, the mispredict lane and a retire count.

Test Plan:
1. Reset, dispatch 3 ROB_REG (rd = 1, 2, 3), then CDB writes tags 2, 1, 0 on channels 0, 1, 2 in one cycle -> next cycle commit_valid = 2'b11 with rd 1, 2; following cycle lane0 rd = 3; count returns to 0.
2. DEPTH = 8: dispatch 8 -> disp_ready = 0, count = 8. Complete head, dispatch in the same cycle -> dispatch blocked; next cycle accepted with disp_tag = 0 (wrap).
3. Head is a ready store, store_ack held low 3 cycles -> store_commit high 3 cycles, no retire. store_ack = 1 -> retires; a younger ready REG commits in the next cycle, not alongside.
4. BR at head with pred_pc = 0x60 and act_pc = 0x40, with a ready REG behind it -> BR retires in lane0, lane1 suppressed. Next cycle flush = 1, flush_pc = 0x40, count = 0.
5. Query tag 4, with tag 4 not ready and CDB channel 1 writing tag 4 = 0xDEADBEEF in the same cycle -> q_ready = 1, q_data = 0xDEADBEEF.
6. Assert rst low mid-operation with 5 entries busy -> all outputs 0 asynchronously, count = 0; disp_ready = 1 after release.
